// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store initiator with sub-word extract and read-modify-write merge
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  input  logic                  req_store_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  misaligned_o,
  output logic                  illegal_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state, next_state;

  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merge_q;
  logic [DATA_WIDTH-1:0] load_data_q;
  logic                  misaligned_q;
  logic                  illegal_q;

  logic                  accept;
  logic                  req_illegal;
  logic                  req_misaligned;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged;

  assign accept = req_valid_i && (state == IDLE);

  // funct3[1:0] encodes access size for both loads and stores; bit 2 is the unsigned flag for loads
  always_comb begin
    if (req_store_i) begin
      req_illegal = req_funct3_i[2] || (req_funct3_i[1:0] == 2'b11);
    end else begin
      req_illegal = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
    end
    req_misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                     ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          if (req_illegal || req_misaligned) begin
            next_state = DONE;
          end else if (!req_store_i) begin
            next_state = LOAD;
          end else if (req_funct3_i[1:0] == 2'b10) begin
            next_state = STORE;
          end else begin
            next_state = RMW_RD;
          end
        end
      end
      LOAD:    next_state = DONE;
      STORE:   next_state = DONE;
      RMW_RD:  next_state = RMW_WR;
      RMW_WR:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    ld_half = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{ld_byte[7] & ~funct3_q[2]}}, ld_byte};
      2'b01:   load_ext = {{16{ld_half[15] & ~funct3_q[2]}}, ld_half};
      default: load_ext = mem_rdata_i;
    endcase
  end

  always_comb begin
    merged = merge_q;
    if (funct3_q[0]) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Memory strobes are gated by reset so a write pending in the reset cycle never lands
  always_comb begin
    ready_o     = (state == IDLE);
    done_o      = (state == DONE);
    mem_read_o  = !reset && ((state == LOAD) || (state == RMW_RD));
    mem_write_o = !reset && ((state == STORE) || (state == RMW_WR));
    mem_wdata_o = '0;
    if (state == STORE) begin
      mem_wdata_o = wdata_q;
    end else if (state == RMW_WR) begin
      mem_wdata_o = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      load_data_q  <= '0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      if (accept) begin
        funct3_q     <= req_funct3_i;
        addr_q       <= req_addr_i;
        wdata_q      <= req_wdata_i;
        illegal_q    <= req_illegal;
        misaligned_q <= !req_illegal && req_misaligned;
      end
      if (state == LOAD) begin
        load_data_q <= load_ext;
      end
      if (state == RMW_RD) begin
        merge_q <= mem_rdata_i;
      end
    end
  end

  assign load_data_o  = load_data_q;
  assign misaligned_o = misaligned_q;
  assign illegal_o    = illegal_q;
  assign mem_addr_o   = {addr_q[DATA_WIDTH-1:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed table-driven bench for load_store_unit with a word-addressed memory model
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ready;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        illegal;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];
  logic        pl_en;
  logic [31:0] pl_addr;
  logic [31:0] pl_data;

  int checks;
  int failures;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_store_i  (req_store),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .ready_o      (ready),
    .done_o       (done),
    .load_data_o  (load_data),
    .misaligned_o (misaligned),
    .illegal_o    (illegal),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? mem[mem_addr[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr[7:2]] <= pl_data;
    if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
  end

  typedef struct {
    string       name;
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        chk_data;
    logic [31:0] data;
    logic        mis;
    logic        ill;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] data, output logic mis, output logic ill,
                         output int acc, output int both);
    lat = 99; data = 'x; mis = 'x; ill = 'x; acc = 0; both = 0;
    wait_ready();
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_read || mem_write) acc++;
      if (mem_read && mem_write) both++;
      if (done) begin
        lat = c; data = load_data; mis = misaligned; ill = illegal;
        break;
      end
    end
  endtask

  function automatic vec_t mk(input string n, input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int lat, input logic cd, input logic [31:0] d,
                              input logic mis, input logic ill);
    vec_t v;
    v.name = n; v.store = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.lat = lat;
    v.chk_data = cd; v.data = d; v.mis = mis; v.ill = ill;
    return v;
  endfunction

  initial begin
    int          lat, acc, both, accepts, dones, rds, wrs;
    logic [31:0] data;
    logic        mis, ill;

    checks = 0; failures = 0;
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0; req_addr = 0; req_wdata = 0;
    pl_en = 1'b0; pl_addr = 0; pl_data = 0;

    tbl.push_back(mk("sw_10",       1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 0, 0, 0, 0));
    tbl.push_back(mk("lw_10",       0, 3'b010, 32'h10, 0, 2, 1, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mk("sb_22",       1, 3'b000, 32'h22, 32'h123456AA, 3, 0, 0, 0, 0));
    tbl.push_back(mk("lw_20_sb",    0, 3'b010, 32'h20, 0, 2, 1, 32'h11AA3344, 0, 0));
    tbl.push_back(mk("sh_20",       1, 3'b001, 32'h20, 32'h9999BEEF, 3, 0, 0, 0, 0));
    tbl.push_back(mk("lw_20_sh",    0, 3'b010, 32'h20, 0, 2, 1, 32'h11AABEEF, 0, 0));
    tbl.push_back(mk("lb_32",       0, 3'b000, 32'h32, 0, 2, 1, 32'hFFFFFFFF, 0, 0));
    tbl.push_back(mk("lbu_32",      0, 3'b100, 32'h32, 0, 2, 1, 32'h000000FF, 0, 0));
    tbl.push_back(mk("lh_32",       0, 3'b001, 32'h32, 0, 2, 1, 32'hFFFF80FF, 0, 0));
    tbl.push_back(mk("lhu_30",      0, 3'b101, 32'h30, 0, 2, 1, 32'h00007F01, 0, 0));
    tbl.push_back(mk("lb_31",       0, 3'b000, 32'h31, 0, 2, 1, 32'h0000007F, 0, 0));
    tbl.push_back(mk("lb_33",       0, 3'b000, 32'h33, 0, 2, 1, 32'hFFFFFF80, 0, 0));
    tbl.push_back(mk("lhu_32",      0, 3'b101, 32'h32, 0, 2, 1, 32'h000080FF, 0, 0));
    tbl.push_back(mk("lw_12_mis",   0, 3'b010, 32'h12, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk("sh_31_mis",   1, 3'b001, 32'h31, 32'h0000CAFE, 1, 0, 0, 1, 0));
    tbl.push_back(mk("ld_011_ill",  0, 3'b011, 32'h30, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk("ld_110_ill",  0, 3'b110, 32'h12, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk("st_100_ill",  1, 3'b100, 32'h30, 32'h0, 1, 0, 0, 0, 1));
    tbl.push_back(mk("lw_30_after", 0, 3'b010, 32'h30, 0, 2, 1, 32'h80FF7F01, 0, 0));
    tbl.push_back(mk("lw_10_after", 0, 3'b010, 32'h10, 0, 2, 1, 32'hDEADBEEF, 0, 0));

    repeat (3) @(negedge clk);
    chk("rst_mem_read_forced", {31'b0, mem_read}, 0);
    chk("rst_mem_write_forced", {31'b0, mem_write}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 1);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_flags", {30'b0, misaligned, illegal}, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    preload(32'h20, 32'h11223344);
    preload(32'h30, 32'h80FF7F01);
    preload(32'h24, 32'h55667788);

    foreach (tbl[i]) begin
      run_req(tbl[i].store, tbl[i].f3, tbl[i].addr, tbl[i].wdata, lat, data, mis, ill, acc, both);
      chk({tbl[i].name, "_latency"}, lat, tbl[i].lat);
      chk({tbl[i].name, "_misaligned"}, {31'b0, mis}, {31'b0, tbl[i].mis});
      chk({tbl[i].name, "_illegal"}, {31'b0, ill}, {31'b0, tbl[i].ill});
      chk({tbl[i].name, "_rd_wr_overlap"}, both, 0);
      if (tbl[i].chk_data) chk({tbl[i].name, "_data"}, data, tbl[i].data);
      if (tbl[i].lat == 1) chk({tbl[i].name, "_no_mem_access"}, acc, 0);
    end

    // Reset held for three cycles while an SB sits in its write-back state
    wait_ready();
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h25; req_wdata = 32'h000000AA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rmw_wr_reached", {31'b0, mem_write}, 1);
    reset = 1'b1;
    #1 chk("rst_gates_write", {31'b0, mem_write}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_ready", {31'b0, ready}, 1);
    chk("midrst_done", {31'b0, done}, 0);
    chk("midrst_load_data", load_data, 0);
    chk("midrst_mem_strobes", {30'b0, mem_read, mem_write}, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midrst_no_done", dones, 0);
    chk("midrst_word_unchanged", mem[32'h24 >> 2], 32'h55667788);

    // Load request held valid: one accept per IDLE visit, no repeats
    wait_ready();
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 0;
    accepts = 0; dones = 0; rds = 0; wrs = 0;
    for (int i = 0; i < 12; i++) begin
      if (ready && req_valid) accepts++;
      if (done) dones++;
      if (mem_read) rds++;
      if (mem_write) wrs++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_lw_accepts", accepts, 4);
    chk("b2b_lw_dones", dones, 4);
    chk("b2b_lw_reads", rds, 4);
    chk("b2b_lw_writes", wrs, 0);
    chk("b2b_lw_data", load_data, 32'hDEADBEEF);

    // SB held valid: three full read-modify-write passes in 12 cycles
    wait_ready();
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'h00000055;
    accepts = 0; wrs = 0;
    for (int i = 0; i < 12; i++) begin
      if (ready && req_valid) accepts++;
      if (mem_write) wrs++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_sb_accepts", accepts, 3);
    chk("b2b_sb_writes", wrs, 3);
    run_req(1'b0, 3'b010, 32'h20, 0, lat, data, mis, ill, acc, both);
    chk("b2b_sb_word", data, 32'h11AA55EF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
